// File: rtl/pipelined_mem_responder_pkg.sv
// Shared constants and helpers for the cache-fill memory responder.
// Line size and read latency are common to the responder and the fill FSM.
package pipelined_mem_responder_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_INDEX_W = 15;
  localparam int LINE_WORDS  = 8;
  localparam int PEND_W      = 3;

  // 4-bit carry-lookahead adder: {carry_out, sum}
  function automatic logic [4:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & c[3]);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/pipelined_mem_responder_stage.sv
// One {valid, addr, data} stage of the read-return pipeline.
// Payload loads only with a valid word, so bubbles leave it holding.
module mem_pipe_stage #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter bit RST_DATA = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
    end
  end

  // Output stage clears its payload so the visible outputs reset to 0
  if (RST_DATA) begin : g_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_q <= '0;
        data_q <= '0;
      end else if (valid_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end else begin : g_nrst
    always_ff @(posedge clk) begin
      if (valid_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipelined_mem_responder.sv
// Main-memory responder: fixed-latency pipelined word reads, write-through
// word writes, in-flight read counter for the fill FSM.
module pipelined_mem_responder
  import pipelined_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] data_addr,
  output logic [PEND_W-1:0] pending
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic               rd_acc;
  logic               wr_acc;
  logic               retire;
  logic [INDEX_W-1:0] idx;
  logic               addr_unused;

  logic [LATENCY:0]             v;
  logic [LATENCY:0][ADDR_W-1:0] a;
  logic [LATENCY:0][DATA_W-1:0] d;

  assign rd_acc      = enable & ~wr;
  assign wr_acc      = enable & wr;
  assign idx         = addr[INDEX_W:1];
  assign addr_unused = addr[0];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[idx] <= data_in;
    end
  end

  // Read data is captured at issue, so later writes never reach it
  assign v[0] = rd_acc;
  assign a[0] = {addr[ADDR_W-1:1], 1'b0};
  assign d[0] = mem_q[idx];

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    mem_pipe_stage #(
      .AW      (ADDR_W),
      .DW      (DATA_W),
      .RST_DATA(i == LATENCY - 1)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst),
      .valid_i(v[i]),
      .addr_i (a[i]),
      .data_i (d[i]),
      .valid_o(v[i+1]),
      .addr_o (a[i+1]),
      .data_o (d[i+1])
    );
  end

  assign data_valid = v[LATENCY];
  assign data_addr  = a[LATENCY];
  assign data_out   = d[LATENCY];
  assign retire     = v[LATENCY];

  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic [3:0]        delta;
  logic [4:0]        pend_sum;
  logic [1:0]        pend_unused;

  always_comb begin
    delta = 4'b0000;
    unique case (1'b1)
      (rd_acc & ~retire): delta = 4'b0001;
      (~rd_acc & retire): delta = 4'b1111;
      default:            delta = 4'b0000;
    endcase
  end

  assign pend_sum    = cla4({1'b0, pending_q}, delta, 1'b0);
  assign pending_d   = pend_sum[PEND_W-1:0];
  assign pend_unused = pend_sum[4:3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Directed bench for pipelined_mem_responder (LATENCY=4, INDEX_W=8).
// A small word model tracks writes; reads capture it at issue.
module tb_pipelined_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [15:0] data_addr;
  logic [2:0]  pending;

  always #5 clk = ~clk;

  pipelined_mem_responder #(
    .ADDR_W (16),
    .DATA_W (16),
    .LATENCY(4),
    .INDEX_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_addr (data_addr),
    .pending   (pending)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] model [256];
  bit          sv [32];
  bit          sw [32];
  logic [15:0] sa [32];
  logic [15:0] sd [32];
  logic [15:0] cd [32];
  logic [15:0] last_d;
  logic [15:0] last_a;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    for (int i = 0; i < 32; i++) begin
      sv[i] = 1'b0;
      sw[i] = 1'b0;
      sa[i] = '0;
      sd[i] = '0;
      cd[i] = '0;
    end
  endtask

  task automatic put(int j, bit w, logic [15:0] a, logic [15:0] d);
    sv[j] = 1'b1;
    sw[j] = w;
    sa[j] = a;
    sd[j] = d;
  endtask

  task automatic wr_word(logic [15:0] a, logic [15:0] d);
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    model[a[8:1]] = d;
    tick();
    enable  = 1'b0;
    wr      = 1'b0;
  endtask

  task automatic run(string tag, int n);
    for (int j = 0; j < n; j++) begin
      int  p;
      int  k;
      bit  rd;
      enable  = sv[j];
      wr      = sw[j];
      addr    = sa[j];
      data_in = sd[j];
      if (sv[j] && !sw[j]) cd[j] = model[sa[j][8:1]];
      if (sv[j] && sw[j])  model[sa[j][8:1]] = sd[j];
      tick();
      enable  = 1'b0;
      wr      = 1'b0;
      addr    = 'x;
      data_in = '0;
      k  = j - 3;
      rd = (k >= 0) && sv[k] && !sw[k];
      chk($sformatf("%s dv@%0d", tag, j), data_valid, rd);
      if (rd) begin
        last_d = cd[k];
        last_a = {sa[k][15:1], 1'b0};
        chk($sformatf("%s addr@%0d", tag, j), data_addr, last_a);
      end
      chk($sformatf("%s data@%0d", tag, j), data_out, last_d);
      p = 0;
      for (int i = j - 3; i <= j; i++)
        if (i >= 0 && sv[i] && !sw[i]) p++;
      chk($sformatf("%s pend@%0d", tag, j), pending, p);
    end
  endtask

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    data_in = '0;
    last_d  = '0;
    last_a  = '0;
    #3;
    chk("rst dv", data_valid, 0);
    chk("rst data", data_out, 0);
    chk("rst addr", data_addr, 0);
    chk("rst pend", pending, 0);
    #9 rst = 1'b1;
    tick();

    wr_word(16'h0010, 16'hBEEF);
    for (int i = 0; i < 8; i++)
      wr_word(16'h0120 + 16'(2 * i), 16'hA000 + 16'(i));
    wr_word(16'h0040, 16'h5555);
    wr_word(16'h0060, 16'h0601);
    wr_word(16'h0062, 16'h0602);
    wr_word(16'h0064, 16'h0603);

    // single read
    clr();
    put(0, 0, 16'h0010, 0);
    run("single", 6);
    chk("single word", last_d, 16'hBEEF);

    // line fill
    clr();
    for (int i = 0; i < 8; i++) put(i, 0, 16'h0120 + 16'(2 * i), 0);
    run("fill", 13);
    chk("fill last", last_d, 16'hA007);

    // read-after-write ordering
    clr();
    put(0, 0, 16'h0040, 0);
    put(1, 1, 16'h0040, 16'h1234);
    put(2, 0, 16'h0040, 0);
    run("raw", 7);
    chk("raw new", last_d, 16'h1234);
    chk("raw old", cd[0], 16'h5555);

    // bubbles
    clr();
    put(0, 0, 16'h0060, 0);
    put(2, 0, 16'h0062, 0);
    put(3, 0, 16'h0064, 0);
    run("bubble", 8);

    // reset mid-fill
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1;
      wr     = 1'b0;
      addr   = 16'h0120 + 16'(2 * i);
      tick();
    end
    enable = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst dv", data_valid, 0);
    chk("midrst pend", pending, 0);
    chk("midrst data", data_out, 0);
    last_d = '0;
    last_a = '0;
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("postrst dv@%0d", i), data_valid, 0);
      chk($sformatf("postrst pend@%0d", i), pending, 0);
    end
    clr();
    for (int i = 0; i < 3; i++) put(i, 0, 16'h0120 + 16'(2 * i), 0);
    run("keep", 7);
    chk("keep word", last_d, 16'hA002);

    // odd address and index alias
    wr_word(16'h0010, 16'hCAFE);
    clr();
    put(0, 0, 16'h0011, 0);
    put(1, 0, 16'h0010, 0);
    put(2, 0, 16'h0210, 0);
    run("alias", 7);
    chk("alias word", last_d, 16'hCAFE);
    chk("alias addr", last_a, 16'h0210);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
